// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer for the multi-cycle MIPS datapath.
// Runs a WIDTH-step shift-add or restoring-divide loop on magnitudes, then sign-corrects.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             hilo_write,
   output logic             hilo_src,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RUN  = 3'd1;
   localparam logic [2:0] ST_FIX  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_DZ   = 3'd4;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic [2:0]       state, stateNext;
   logic [CW-1:0]    stepCnt;
   logic [WIDTH-1:0] magA, magB;
   logic [WIDTH-1:0] accHi, accLo;
   logic             negRes, negRem;

   logic [WIDTH-1:0]   absA, absB;
   logic               acceptReq, divByZero;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divTrial;
   logic [2*WIDTH-1:0] prodMag, prodFix;
   logic [WIDTH-1:0]   quotFix, remFix;

   // Magnitudes of the most negative value wrap to themselves, which is
   // exactly the correct unsigned magnitude.
   assign absA = a[WIDTH-1] ? -a : a;
   assign absB = b[WIDTH-1] ? -b : b;

   assign divByZero = start && op && (b == '0);
   assign acceptReq = start && !divByZero;

   // Shift-add step: accHi holds P_hi, accLo holds P_lo; the carry shifts in.
   assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : '0);

   // Restoring step: accHi holds R, accLo holds Q. R < |b| <= 2^(WIDTH-1),
   // so the shifted remainder always fits WIDTH+1 bits and the top bit of
   // the trial is a valid sign.
   assign divShift = {accHi, accLo[WIDTH-1]};
   assign divTrial = divShift - {1'b0, magB};

   assign prodMag = {accHi, accLo};
   assign prodFix = negRes ? -prodMag : prodMag;
   assign quotFix = negRes ? -accLo : accLo;
   assign remFix  = negRem ? -accHi : accHi;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE: begin
            if (divByZero)      stateNext = ST_DZ;
            else if (acceptReq) stateNext = ST_RUN;
         end
         ST_RUN:  if (stepCnt == LAST_STEP) stateNext = ST_FIX;
         ST_FIX:  stateNext = ST_DONE;
         ST_DONE: stateNext = ST_IDLE;
         ST_DZ:   stateNext = ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stepCnt  <= '0;
         magA     <= '0;
         magB     <= '0;
         accHi    <= '0;
         accLo    <= '0;
         negRes   <= 1'b0;
         negRem   <= 1'b0;
         hilo_src <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (acceptReq) begin
                  stepCnt  <= '0;
                  magA     <= absA;
                  magB     <= absB;
                  accHi    <= '0;
                  accLo    <= op ? absA : absB;
                  negRes   <= a[WIDTH-1] ^ b[WIDTH-1];
                  negRem   <= a[WIDTH-1];
                  hilo_src <= op;
               end
            end
            ST_RUN: begin
               stepCnt <= stepCnt + 1'b1;
               if (!hilo_src) begin
                  accHi <= mulSum[WIDTH:1];
                  accLo <= {mulSum[0], accLo[WIDTH-1:1]};
               end else if (!divTrial[WIDTH]) begin
                  accHi <= divTrial[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], 1'b1};
               end else begin
                  accHi <= divShift[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   // Results only move in FIX; a reset mid-operation leaves them cleared.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == ST_FIX) begin
         if (hilo_src) begin
            hi <= remFix;
            lo <= quotFix;
         end else begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
         end
      end
   end

   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign hilo_write = (state == ST_DONE);
   assign div_zero   = (state == ST_DZ);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, div-by-zero,
// start-while-busy and mid-run reset.
module tb_muldiv_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a, b;
   logic        busy, done, hilo_write, hilo_src, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_seq #(.WIDTH(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .hilo_write (hilo_write),
      .hilo_src   (hilo_src),
      .div_zero   (div_zero),
      .hi         (hi),
      .lo         (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Called in the cycle after edge 0; returns the edge index after which done was seen.
   task automatic waitDone(output int n, output logic sawDz);
      n = 0;
      sawDz = 1'b0;
      while (!done && n < 60) begin
         @(posedge clock);
         @(negedge clock);
         n++;
         sawDz = sawDz | div_zero;
      end
   endtask

   task automatic runOp(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                        input logic [31:0] expHi, input logic [31:0] expLo, input string tag);
      int   n;
      logic sawDz;
      @(negedge clock);
      start = 1'b1; op = opIn; a = aIn; b = bIn;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check({tag, " busy_after_edge0"}, 64'(busy), 64'd1);
      waitDone(n, sawDz);
      check({tag, " done_edge"}, 64'(n), 64'd33);
      check({tag, " hi"}, 64'(hi), 64'(expHi));
      check({tag, " lo"}, 64'(lo), 64'(expLo));
      check({tag, " hilo_write"}, 64'(hilo_write), 64'd1);
      check({tag, " busy_in_done"}, 64'(busy), 64'd1);
      check({tag, " hilo_src"}, 64'(hilo_src), 64'(opIn));
      check({tag, " no_div_zero"}, 64'(sawDz), 64'd0);
      @(negedge clock);
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      check({tag, " busy_fallen"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int   doneCount;
      int   n;
      logic sawDz;
      logic sawDone;

      reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      #12;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset hilo_write", 64'(hilo_write), 64'd0);
      check("reset div_zero", 64'(div_zero), 64'd0);
      check("reset hilo_src", 64'(hilo_src), 64'd0);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      @(negedge clock);
      reset = 1'b1;

      runOp(1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult 7x-3");
      runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult -1x-1");
      runOp(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "mult max");

      // Divide by zero: one-cycle pulse, results and source untouched.
      @(negedge clock);
      start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check("dz div_zero", 64'(div_zero), 64'd1);
      check("dz busy", 64'(busy), 64'd1);
      check("dz hilo_write", 64'(hilo_write), 64'd0);
      check("dz done", 64'(done), 64'd0);
      @(posedge clock);
      @(negedge clock);
      check("dz div_zero_cleared", 64'(div_zero), 64'd0);
      check("dz busy_cleared", 64'(busy), 64'd0);
      check("dz hilo_write_after", 64'(hilo_write), 64'd0);
      check("dz hi_kept", 64'(hi), 64'h3FFF_FFFF);
      check("dz lo_kept", 64'(lo), 64'h0000_0001);
      check("dz hilo_src_kept", 64'(hilo_src), 64'd0);

      runOp(1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
      runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div min/-1");

      // start held high throughout: only edge 0 and the edge after busy falls accept.
      @(negedge clock);
      start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
      doneCount = 0;
      for (int e = 0; e <= 35; e++) begin
         @(posedge clock);
         @(negedge clock);
         if (e == 0) begin
            a = 32'd100;
            b = 32'd5;
         end
         if (done) doneCount++;
         if (e == 33) begin
            check("busy-start done", 64'(done), 64'd1);
            check("busy-start lo", 64'(lo), 64'd6);
            check("busy-start hi", 64'(hi), 64'd0);
         end
         if (e == 34) check("busy-start idle_gap", 64'(busy), 64'd0);
         if (e == 35) check("busy-start reaccept", 64'(busy), 64'd1);
      end
      start = 1'b0;
      check("busy-start done_count", 64'(doneCount), 64'd1);
      waitDone(n, sawDz);
      check("second req done_edge", 64'(n), 64'd33);
      check("second req lo", 64'(lo), 64'd500);
      check("second req hi", 64'(hi), 64'd0);
      @(negedge clock);

      // Reset at edge 10 of a multiply aborts it and clears results.
      @(negedge clock);
      start = 1'b1; op = 1'b0; a = 32'h0001_2345; b = 32'h0000_0010;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("abort busy_async", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      @(negedge clock);
      check("abort hi", 64'(hi), 64'd0);
      check("abort lo", 64'(lo), 64'd0);
      reset = 1'b1;
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clock);
         sawDone = sawDone | done | hilo_write;
      end
      check("abort no_done", 64'(sawDone), 64'd0);
      check("abort lo_still_zero", 64'(lo), 64'd0);
      runOp(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, "mult 3x4");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
